// File: rtl/fpga1_sender.sv
// rtl/fpga1_sender.sv - FPGA1->FPGA2 burst transmitter with req/rdy/ack handshake and timeouts
module fpga1_sender #(
    parameter int BURST_LEN      = 10,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] data_out,
    output logic        req_out,
    output logic        send_done,
    input  logic        rdy_in,
    input  logic        ack_in,
    output logic        busy,
    output logic        done_ok,
    output logic        err_timeout,
    output logic [9:0]  words_sent
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    // Non-final words leave HOLD one cycle early: the FETCH cycle completes the hold window.
    localparam logic [HW-1:0] HOLD_MID   = HW'(HOLD_CYCLES - 2);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [9:0]    BURST_LAST = 10'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        FETCH,
        HOLD,
        WAIT_ACK,
        GAP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;

    logic rdy_meta, rdy_s, rdy_d;
    logic ack_meta, ack_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
            rdy_d    <= 1'b0;
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            rdy_meta <= rdy_in;
            rdy_s    <= rdy_meta;
            rdy_d    <= rdy_s;
            ack_meta <= ack_in;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            s_ready     <= 1'b0;
            data_out    <= '0;
            req_out     <= 1'b0;
            send_done   <= 1'b0;
            busy        <= 1'b0;
            done_ok     <= 1'b0;
            err_timeout <= 1'b0;
            words_sent  <= '0;
        end else begin
            done_ok     <= 1'b0;
            err_timeout <= 1'b0;
            // Receiver dropping rdy mid-burst is an abort, reported like a timeout.
            if ((state == FETCH || state == HOLD) && !rdy_s) begin
                s_ready     <= 1'b0;
                req_out     <= 1'b0;
                send_done   <= 1'b0;
                err_timeout <= 1'b1;
                gap_cnt     <= '0;
                state       <= GAP;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            words_sent <= '0;
                            timer      <= '0;
                            req_out    <= 1'b1;
                            busy       <= 1'b1;
                            state      <= WAIT_RDY;
                        end
                    end
                    WAIT_RDY: begin
                        if (rdy_s) begin
                            s_ready <= 1'b1;
                            state   <= FETCH;
                        end else if (timer == TIMER_LAST) begin
                            req_out     <= 1'b0;
                            err_timeout <= 1'b1;
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    FETCH: begin
                        if (s_valid) begin
                            data_out   <= s_data;
                            s_ready    <= 1'b0;
                            hold_cnt   <= '0;
                            words_sent <= words_sent + 10'd1;
                            state      <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (words_sent == BURST_LAST) begin
                            if (hold_cnt == HOLD_LAST) begin
                                send_done <= 1'b1;
                                timer     <= '0;
                                state     <= WAIT_ACK;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end else if (hold_cnt == HOLD_MID) begin
                            s_ready <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    WAIT_ACK: begin
                        // A falling rdy also completes, covering an ack pulse lost in synchronization.
                        if (ack_s || (rdy_d && !rdy_s)) begin
                            req_out   <= 1'b0;
                            send_done <= 1'b0;
                            done_ok   <= 1'b1;
                            gap_cnt   <= '0;
                            state     <= GAP;
                        end else if (timer == TIMER_LAST) begin
                            req_out     <= 1'b0;
                            send_done   <= 1'b0;
                            err_timeout <= 1'b1;
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fpga1_sender.sv
// tb/tb_fpga1_sender.sv - directed bench for fpga1_sender
module tb_fpga1_sender;
    logic        clk = 1'b0;
    logic        rst, start, s_valid, rdy_in, ack_in;
    logic [31:0] s_data;
    logic        s_ready, req_out, send_done, busy, done_ok, err_timeout;
    logic [31:0] data_out;
    logic [9:0]  words_sent;

    int total = 0;
    int bad   = 0;
    int idx   = 0;

    int          nwords, sd_run;
    logic [31:0] vals [0:15];
    int          runs [0:15];
    bit          done_seen, err_seen, sd_seen, pulse_long, idle_reached, sready_early;
    logic        post_req, post_sd, start_req, start_busy;
    logic [9:0]  post_ws;

    fpga1_sender dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .data_out(data_out), .req_out(req_out), .send_done(send_done),
        .rdy_in(rdy_in), .ack_in(ack_in), .busy(busy), .done_ok(done_ok),
        .err_timeout(err_timeout), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    // Source model: the next word is 0xA0000001 + number of words already accepted.
    task automatic tick();
        bit hs;
        hs = s_valid & s_ready;
        @(posedge clk);
        #1;
        if (hs) idx++;
        s_data = 32'hA0000001 + idx;
    endtask

    task automatic run_burst(input int stall_len, input int abort_after, input bit use_ack);
        logic [31:0] last;
        int run, stall_cnt, ack_state;
        idx = 0; s_data = 32'hA0000001; s_valid = 1'b1;
        done_seen = 0; err_seen = 0; sd_seen = 0; sd_run = -1; nwords = 0;
        post_req = 1'bx; post_sd = 1'bx; post_ws = 'x;
        for (int i = 0; i < 16; i++) begin vals[i] = '0; runs[i] = -1; end
        last = data_out; run = 0; stall_cnt = 0; ack_state = 0;
        start = 1'b1; tick(); start = 1'b0;
        start_req = req_out; start_busy = busy;
        sready_early = 0;
        repeat (4) begin tick(); if (s_ready) sready_early = 1; end
        rdy_in = 1'b1;
        for (int c = 0; c < 800 && !(done_seen || err_seen); c++) begin
            tick();
            if (ack_state == 1) begin ack_in = 1'b0; ack_state = 2; end
            if (send_done && !sd_seen) begin
                sd_seen = 1; sd_run = run;
                if (use_ack) begin ack_in = 1'b1; ack_state = 1; end
                else rdy_in = 1'b0;
            end
            if (data_out !== last) begin
                if (nwords > 0 && nwords <= 16) runs[nwords-1] = run;
                if (nwords < 16) vals[nwords] = data_out;
                nwords++; last = data_out; run = 1;
                if (abort_after > 0 && nwords == abort_after) rdy_in = 1'b0;
            end else begin
                run++;
            end
            if (idx == 2 && stall_cnt < stall_len) begin s_valid = 1'b0; stall_cnt++; end
            else s_valid = 1'b1;
            if (done_ok) done_seen = 1;
            if (err_timeout) err_seen = 1;
            if (done_ok || err_timeout) begin
                post_req = req_out; post_sd = send_done; post_ws = words_sent;
            end
        end
        tick();
        pulse_long = done_ok | err_timeout;
        ack_in = 1'b0; rdy_in = 1'b0;
        idle_reached = 0;
        for (int c = 0; c < 40 && !idle_reached; c++) begin tick(); if (!busy) idle_reached = 1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; rdy_in = 1'b0; ack_in = 1'b0;
        repeat (3) tick();
        total++;
        if ({data_out, req_out, send_done, s_ready, busy, done_ok, err_timeout, words_sent} !== 48'd0) begin
            bad++; $display("FAIL reset_outputs: got %0h want 0",
                {data_out, req_out, send_done, s_ready, busy, done_ok, err_timeout, words_sent});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        run_burst(0, 0, 1'b1);
        total++; if (start_req !== 1'b1) begin bad++; $display("FAIL nom_req: got %0b want 1", start_req); end
        total++; if (start_busy !== 1'b1) begin bad++; $display("FAIL nom_busy: got %0b want 1", start_busy); end
        total++; if (sready_early !== 1'b0) begin bad++; $display("FAIL nom_sready_early: got %0b want 0", sready_early); end
        total++; if (nwords != 10) begin bad++; $display("FAIL nom_nwords: got %0d want 10", nwords); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (vals[i] !== 32'hA0000001 + i) begin bad++; $display("FAIL nom_word%0d: got %0h want %0h", i, vals[i], 32'hA0000001 + i); end
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (runs[i] != 8) begin bad++; $display("FAIL nom_hold%0d: got %0d want 8", i, runs[i]); end
        end
        total++; if (sd_run != 8) begin bad++; $display("FAIL nom_last_hold: got %0d want 8", sd_run); end
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL nom_done: got %0b want 1", done_seen); end
        total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL nom_err: got %0b want 0", err_seen); end
        total++; if ({post_req, post_sd} !== 2'b00) begin bad++; $display("FAIL nom_post_req_sd: got %0b want 0", {post_req, post_sd}); end
        total++; if (post_ws !== 10'd10) begin bad++; $display("FAIL nom_words_sent: got %0d want 10", post_ws); end
        total++; if (pulse_long !== 1'b0) begin bad++; $display("FAIL nom_pulse_width: got %0b want 0", pulse_long); end
        total++; if (idle_reached !== 1'b1) begin bad++; $display("FAIL nom_idle: got %0b want 1", idle_reached); end
        total++; if (words_sent !== 10'd10) begin bad++; $display("FAIL nom_ws_hold: got %0d want 10", words_sent); end
    endtask

    task automatic test_source_stall();
        run_burst(20, 0, 1'b1);
        total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL stall_err: got %0b want 0", err_seen); end
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL stall_done: got %0b want 1", done_seen); end
        total++; if (runs[1] != 21) begin bad++; $display("FAIL stall_word2_hold: got %0d want 21", runs[1]); end
        total++; if (runs[2] != 8) begin bad++; $display("FAIL stall_word3_hold: got %0d want 8", runs[2]); end
        total++; if (vals[2] !== 32'hA0000003) begin bad++; $display("FAIL stall_word3: got %0h want a0000003", vals[2]); end
        total++; if (post_ws !== 10'd10) begin bad++; $display("FAIL stall_words_sent: got %0d want 10", post_ws); end
    endtask

    task automatic test_missed_ack();
        run_burst(0, 0, 1'b0);
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL mack_done: got %0b want 1", done_seen); end
        total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL mack_err: got %0b want 0", err_seen); end
        total++; if ({post_req, post_sd} !== 2'b00) begin bad++; $display("FAIL mack_post_req_sd: got %0b want 0", {post_req, post_sd}); end
        total++; if (post_ws !== 10'd10) begin bad++; $display("FAIL mack_words_sent: got %0d want 10", post_ws); end
    endtask

    task automatic test_receiver_abort();
        run_burst(0, 4, 1'b1);
        total++; if (err_seen !== 1'b1) begin bad++; $display("FAIL abort_err: got %0b want 1", err_seen); end
        total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL abort_done: got %0b want 0", done_seen); end
        total++; if ({post_req, post_sd} !== 2'b00) begin bad++; $display("FAIL abort_post_req_sd: got %0b want 0", {post_req, post_sd}); end
        total++; if (post_ws !== 10'd4) begin bad++; $display("FAIL abort_words_sent: got %0d want 4", post_ws); end
        total++; if (nwords != 4) begin bad++; $display("FAIL abort_nwords: got %0d want 4", nwords); end
        total++; if (idle_reached !== 1'b1) begin bad++; $display("FAIL abort_idle: got %0b want 1", idle_reached); end
    endtask

    task automatic test_no_receiver();
        int  n;
        bit  seen, sr;
        s_valid = 1'b1; rdy_in = 1'b0; n = 0; seen = 0; sr = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 1100 && !seen; c++) begin
            tick(); n++;
            if (s_ready) sr = 1;
            if (err_timeout) seen = 1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL norx_err: got %0b want 1", seen); end
        total++; if (n != 1024) begin bad++; $display("FAIL norx_latency: got %0d want 1024", n); end
        total++; if (req_out !== 1'b0) begin bad++; $display("FAIL norx_req: got %0b want 0", req_out); end
        total++; if (sr !== 1'b0) begin bad++; $display("FAIL norx_sready: got %0b want 0", sr); end
        repeat (2) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy_end: got %0b want 1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_idle: got %0b want 0", busy); end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({req_out, busy} !== 2'b00) begin bad++; $display("FAIL gap_start_ignored: got %0b want 0", {req_out, busy}); end
        end
    endtask

    task automatic test_reset_mid_burst();
        s_valid = 1'b1; rdy_in = 1'b1; idx = 0; s_data = 32'hA0000001;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 300 && data_out !== 32'hA0000006; c++) tick();
        total++; if (data_out !== 32'hA0000006) begin bad++; $display("FAIL rstmid_reach: got %0h want a0000006", data_out); end
        repeat (3) tick();
        rst = 1'b1; tick();
        total++;
        if ({data_out, req_out, send_done, s_ready, busy, done_ok, err_timeout, words_sent} !== 48'd0) begin
            bad++; $display("FAIL rstmid_outputs: got %0h want 0",
                {data_out, req_out, send_done, s_ready, busy, done_ok, err_timeout, words_sent});
        end
        rst = 1'b0; rdy_in = 1'b0;
        repeat (5) tick();
        total++; if ({req_out, busy} !== 2'b00) begin bad++; $display("FAIL rstmid_no_resume: got %0b want 0", {req_out, busy}); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_source_stall();
        test_missed_ack();
        test_receiver_abort();
        test_no_receiver();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
